// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit registered execute stage (AND, OR, ADD, SUB, optional XOR/SHL/SHR/SLT).
// Operands and opcode are sampled on a rising clk edge with in_valid=1; the result
// and flags appear from registers one cycle later with out_valid pulsed high.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  capture a, b, ctrl on this edge
//   a, b      8-bit unsigned operands
//   ctrl      3-bit opcode
//   y         registered result
//   carry     registered carry (ADD) / borrow (SUB) flag
//   negative  registered a<b flag (SUB only)
//   zero      registered y==0 flag (AND/OR/ADD/SUB only)
//   out_valid y and flags hold a new result
//
// Build option: define ALU_EXT_OPS_EN to enable XOR, SHL, SHR and SLT on
// opcodes 011, 100, 101, 111. Without it those opcodes produce y=0, flags 0.
module alu_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] ctrl,
   output logic [7:0] y,
   output logic       carry,
   output logic       negative,
   output logic       zero,
   output logic       out_valid
);

   localparam int unsigned W = 8;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [W:0]   sum_c;
   logic [W:0]   diff_c;
   logic [W-1:0] y_c;
   logic         carry_c;
   logic         negative_c;
   logic         zero_c;

   // Extended 9-bit add/sub; bit 8 of the difference is the borrow (a<b).
   assign sum_c  = {1'b0, a} + {1'b0, b};
   assign diff_c = {1'b0, a} - {1'b0, b};

   // Result and flag selection; unflagged opcodes keep all flags at 0.
   always_comb begin
      y_c        = '0;
      carry_c    = 1'b0;
      negative_c = 1'b0;
      zero_c     = 1'b0;
      case (ctrl)
         OP_AND: begin
            y_c    = a & b;
            zero_c = (y_c == '0);
         end
         OP_OR: begin
            y_c    = a | b;
            zero_c = (y_c == '0);
         end
         OP_ADD: begin
            y_c     = sum_c[W-1:0];
            carry_c = sum_c[W];
            zero_c  = (y_c == '0);
         end
         OP_SUB: begin
            y_c        = diff_c[W-1:0];
            carry_c    = diff_c[W];
            negative_c = diff_c[W];
            zero_c     = (y_c == '0);
         end
`ifdef ALU_EXT_OPS_EN
         OP_XOR: y_c = a ^ b;
         OP_SHL: y_c = a << b[2:0];
         OP_SHR: y_c = a >> b[2:0];
         OP_SLT: y_c = {7'd0, diff_c[W]};
`else
         OP_XOR, OP_SHL, OP_SHR, OP_SLT: y_c = '0;
`endif
         default: y_c = '0;
      endcase
   end

   // Output registers: update only on accepted ops; out_valid is a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y         <= '0;
         carry     <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y        <= y_c;
            carry    <= carry_c;
            negative <= negative_c;
            zero     <= zero_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_8bit.sv
module tb_alu_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] ctrl;
   logic [7:0] y;
   logic       carry;
   logic       negative;
   logic       zero;
   logic       out_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef ALU_EXT_OPS_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic [10:0] last_exp;   // {y, carry, negative, zero} of last accepted op

   alu_8bit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ctrl(ctrl),
      .y(y), .carry(carry), .negative(negative), .zero(zero), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Independent reference computed with integer arithmetic; returns {y,c,n,z}.
   function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [2:0] mc);
      int   ia = int'(ma);
      int   ib = int'(mb);
      int   r  = 0;
      logic c  = 1'b0;
      logic n  = 1'b0;
      logic fl = 1'b1;
      case (mc)
         3'd0: r = ia & ib;
         3'd1: r = ia | ib;
         3'd2: begin r = ia + ib; c = (r > 255); r = r % 256; end
         3'd6: begin c = (ia < ib); n = c; r = (ia - ib + 256) % 256; end
         default: begin
            fl = 1'b0;
            if (EXT) begin
               case (mc)
                  3'd3:    r = ia ^ ib;
                  3'd4:    r = (ia << (ib % 8)) % 256;
                  3'd5:    r = ia >> (ib % 8);
                  default: r = (ia < ib) ? 1 : 0;
               endcase
            end
         end
      endcase
      return {8'(r), c, n, fl && (r == 0)};
   endfunction

   // Drive one op at the falling edge, then wait until just after the capturing edge.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] ic);
      @(negedge clk);
      a = ia; b = ib; ctrl = ic; in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({y, carry, negative, zero, out_valid} !== 12'h000)
         $display("FAIL reset_init: got %h want 000", {y, carry, negative, zero, out_valid});
      else pass_cnt++;
      @(negedge clk) rst = 1'b0;
      issue(8'd200, 8'd100, 3'b010);
      // Pending op at mid-cycle, then async reset before the next edge.
      @(negedge clk);
      a = 8'd77; b = 8'd1; ctrl = 3'b010; in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({y, carry, negative, zero, out_valid} !== 12'h000)
         $display("FAIL reset_async: got %h want 000", {y, carry, negative, zero, out_valid});
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if ({y, carry, negative, zero, out_valid} !== 12'h000)
         $display("FAIL reset_discard: got %h want 000", {y, carry, negative, zero, out_valid});
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   // Vector layout: {a, b, ctrl, y, carry, negative, zero}.
   task automatic test_add();
      logic [29:0] v [3] = '{
         {8'd200, 8'd100, 3'b010, 8'd44, 3'b100},
         {8'd128, 8'd128, 3'b010, 8'd0,  3'b101},
         {8'd1,   8'd2,   3'b010, 8'd3,  3'b000}
      };
      for (int i = 0; i < 3; i++) begin
         issue(v[i][29:22], v[i][21:14], v[i][13:11]);
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {v[i][10:0], 1'b1})
            $display("FAIL add[%0d]: got %h want %h", i,
                     {y, carry, negative, zero, out_valid}, {v[i][10:0], 1'b1});
         else pass_cnt++;
      end
   endtask

   task automatic test_sub();
      logic [29:0] v [3] = '{
         {8'd5,  8'd10, 3'b110, 8'd251, 3'b110},
         {8'd77, 8'd77, 3'b110, 8'd0,   3'b001},
         {8'd10, 8'd3,  3'b110, 8'd7,   3'b000}
      };
      for (int i = 0; i < 3; i++) begin
         issue(v[i][29:22], v[i][21:14], v[i][13:11]);
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {v[i][10:0], 1'b1})
            $display("FAIL sub[%0d]: got %h want %h", i,
                     {y, carry, negative, zero, out_valid}, {v[i][10:0], 1'b1});
         else pass_cnt++;
      end
   endtask

   task automatic test_logic();
      logic [29:0] v [4] = '{
         {8'hF0, 8'h0F, 3'b000, 8'h00, 3'b001},
         {8'hF0, 8'h0F, 3'b001, 8'hFF, 3'b000},
         {8'hF0, 8'hFF, 3'b000, 8'hF0, 3'b000},
         {8'h00, 8'h00, 3'b001, 8'h00, 3'b001}
      };
      for (int i = 0; i < 4; i++) begin
         issue(v[i][29:22], v[i][21:14], v[i][13:11]);
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {v[i][10:0], 1'b1})
            $display("FAIL logic[%0d]: got %h want %h", i,
                     {y, carry, negative, zero, out_valid}, {v[i][10:0], 1'b1});
         else pass_cnt++;
      end
   endtask

   task automatic test_ext();
      logic [29:0] v [6] = '{
         {8'h55, 8'h55, 3'b011, 8'h00,                 3'b000},
         {8'd3,  8'd9,  3'b111, (EX(8'h01)),           3'b000},
         {8'd9,  8'd3,  3'b111, 8'h00,                 3'b000},
         {8'h81, 8'd1,  3'b100, (EX(8'h02)),           3'b000},
         {8'h81, 8'd3,  3'b101, (EX(8'h10)),           3'b000},
         {8'hF0, 8'h0F, 3'b011, (EX(8'hFF)),           3'b000}
      };
      for (int i = 0; i < 6; i++) begin
         issue(v[i][29:22], v[i][21:14], v[i][13:11]);
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {v[i][10:0], 1'b1})
            $display("FAIL ext[%0d]: got %h want %h", i,
                     {y, carry, negative, zero, out_valid}, {v[i][10:0], 1'b1});
         else pass_cnt++;
      end
   endtask

   function automatic logic [7:0] EX(input logic [7:0] val);
      return EXT ? val : 8'h00;
   endfunction

   task automatic test_back_to_back();
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [2:0]  rc;
      logic [10:0] exp;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 3'($urandom);
         exp = model(ra, rb, rc);
         issue(ra, rb, rc);
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {exp, 1'b1})
            $display("FAIL b2b[%0d] a=%h b=%h ctrl=%b: got %h want %h", i, ra, rb, rc,
                     {y, carry, negative, zero, out_valid}, {exp, 1'b1});
         else pass_cnt++;
         last_exp = exp;
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0; a = ~a; b = b + 8'd37; ctrl = ctrl + 3'd1;
         @(posedge clk);
         #1;
         total_cnt++;
         if ({y, carry, negative, zero, out_valid} !== {last_exp, 1'b0})
            $display("FAIL hold[%0d]: got %h want %h", i,
                     {y, carry, negative, zero, out_valid}, {last_exp, 1'b0});
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_ext();
      test_back_to_back();
      test_hold();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
